// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: register-command prefixes, PHY register addresses
// and the register-access controller state encoding.
package ulpi_pkg;

  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;

  localparam logic [5:0] REG_VID_LO = 6'h00;
  localparam logic [5:0] REG_FCTRL  = 6'h04;
  localparam logic [5:0] REG_OTG    = 6'h0A;

  typedef enum logic [2:0] {
    ST_INIT_RD = 3'd0,
    ST_INIT_W1 = 3'd1,
    ST_INIT_W2 = 3'd2,
    ST_IDLE    = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_WAIT    = 3'd5,
    ST_DONE    = 3'd6
  } ctrl_state_e;

  function automatic logic [7:0] ulpi_cmd(input logic wr, input logic [5:0] addr);
    return {(wr ? CMD_REGW : CMD_REGR), addr};
  endfunction

endpackage

// File: rtl/ulpi_rr_arb2.sv
// Two-request round-robin arbiter. Index 0 = software, index 1 = link.
// The port named by served_i is remembered when advance_i pulses.
module ulpi_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       served_i,
  output logic [1:0] gnt_o
);

  // 1 = link was served last, so software wins the first tie
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= served_i;
    end
  end

  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);

endmodule

// File: rtl/ulpi_phy_ctrl.sv
// ULPI PHY register-access controller: optional init sequence (ULPI_PHY_CTRL_INIT_EN),
// then round-robin register reads/writes for the software and link requesters.
module ulpi_phy_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
`ifdef ULPI_PHY_CTRL_INIT_EN
  ,
  parameter logic [7:0] FCTRL_INIT = 8'h40,
  parameter logic [7:0] OTG_INIT   = 8'h00
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_req,
  input  logic       sw_wr,
  input  logic [5:0] sw_addr,
  input  logic [7:0] sw_wdata,
  output logic       sw_ack,
  output logic [7:0] sw_rdata,
  output logic       sw_err,
  input  logic       lk_req,
  input  logic       lk_wr,
  input  logic [5:0] lk_addr,
  input  logic [7:0] lk_wdata,
  output logic       lk_ack,
  output logic [7:0] lk_rdata,
  output logic       lk_err,
  output logic       sie_en,
  output logic [7:0] sie_cmd,
  output logic [7:0] sie_regwd,
  input  logic [7:0] sie_regrd,
  input  logic       sie_busy,
  output logic       ready,
  output logic [7:0] vid_lo,
  output logic       init_err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
`ifdef ULPI_PHY_CTRL_INIT_EN
  localparam ctrl_state_e   ST_RESET = ST_INIT_RD;
`else
  localparam ctrl_state_e   ST_RESET = ST_IDLE;
`endif

  ctrl_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          owner_q, owner_d;
  logic          sie_en_q, sie_en_d;
  logic [7:0]    sie_cmd_q, sie_cmd_d;
  logic [7:0]    sie_regwd_q, sie_regwd_d;
  logic          sw_ack_q, sw_ack_d, sw_err_q, sw_err_d;
  logic [7:0]    sw_rdata_q, sw_rdata_d;
  logic          lk_ack_q, lk_ack_d, lk_err_q, lk_err_d;
  logic [7:0]    lk_rdata_q, lk_rdata_d;
  logic          ready_q, ready_d;
`ifdef ULPI_PHY_CTRL_INIT_EN
  logic [7:0]    vid_lo_q, vid_lo_d;
  logic          init_err_q, init_err_d;
  logic          init_acc_q, init_acc_d;
  ctrl_state_e   ret_q, ret_d;
`endif

  logic [1:0] gnt;
  logic       advance;
  logic       start, start_wr;
  logic [5:0] start_addr;
  logic [7:0] start_wdata;
  logic       fin, fin_ok;

  ulpi_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({lk_req, sw_req}),
    .advance_i (advance),
    .served_i  (owner_q),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    wr_d        = wr_q;
    owner_d     = owner_q;
    sie_en_d    = sie_en_q;
    sie_cmd_d   = sie_cmd_q;
    sie_regwd_d = sie_regwd_q;
    sw_ack_d    = 1'b0;
    sw_err_d    = 1'b0;
    sw_rdata_d  = sw_rdata_q;
    lk_ack_d    = 1'b0;
    lk_err_d    = 1'b0;
    lk_rdata_d  = lk_rdata_q;
    start       = 1'b0;
    start_wr    = 1'b0;
    start_addr  = 6'h00;
    start_wdata = 8'h00;
    fin         = 1'b0;
    fin_ok      = 1'b0;
    advance     = 1'b0;
`ifdef ULPI_PHY_CTRL_INIT_EN
    vid_lo_d    = vid_lo_q;
    init_err_d  = init_err_q;
    init_acc_d  = init_acc_q;
    ret_d       = ret_q;
`endif

    case (state_q)
`ifdef ULPI_PHY_CTRL_INIT_EN
      ST_INIT_RD: begin
        start      = 1'b1;
        start_addr = REG_VID_LO;
        init_acc_d = 1'b1;
        ret_d      = ST_INIT_W1;
      end
      ST_INIT_W1: begin
        start       = 1'b1;
        start_wr    = 1'b1;
        start_addr  = REG_OTG;
        start_wdata = OTG_INIT;
        init_acc_d  = 1'b1;
        ret_d       = ST_INIT_W2;
      end
      ST_INIT_W2: begin
        start       = 1'b1;
        start_wr    = 1'b1;
        start_addr  = REG_FCTRL;
        start_wdata = FCTRL_INIT;
        init_acc_d  = 1'b1;
        ret_d       = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (ready_q && (gnt != 2'b00)) begin
          start       = 1'b1;
          owner_d     = gnt[1];
          start_wr    = gnt[1] ? lk_wr    : sw_wr;
          start_addr  = gnt[1] ? lk_addr  : sw_addr;
          start_wdata = gnt[1] ? lk_wdata : sw_wdata;
`ifdef ULPI_PHY_CTRL_INIT_EN
          init_acc_d  = 1'b0;
          ret_d       = ST_DONE;
`endif
        end
      end
      ST_ISSUE: begin
        if (sie_busy) begin
          sie_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          sie_en_d = 1'b0;
          fin      = 1'b1;
        end
      end
      ST_WAIT: begin
        // cmd/regwd are left untouched here: the SIE re-samples cmd after busy rises
        if (!sie_busy) begin
          fin    = 1'b1;
          fin_ok = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          fin = 1'b1;
        end
      end
      ST_DONE: begin
        advance = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      wr_d        = start_wr;
      sie_en_d    = 1'b1;
      sie_cmd_d   = ulpi_cmd(start_wr, start_addr);
      sie_regwd_d = start_wdata;
      cnt_d       = '0;
      state_d     = ST_ISSUE;
    end

    if (fin) begin
`ifdef ULPI_PHY_CTRL_INIT_EN
      if (init_acc_q) begin
        // init steps advance even after a timeout; the failure is only recorded
        state_d = ret_q;
        if (!fin_ok) begin
          init_err_d = 1'b1;
        end else if (!wr_q) begin
          vid_lo_d = sie_regrd;
        end
      end else
`endif
      begin
        state_d = ST_DONE;
        if (owner_q) begin
          lk_ack_d   = 1'b1;
          lk_err_d   = !fin_ok;
          lk_rdata_d = (fin_ok && !wr_q) ? sie_regrd : 8'h00;
        end else begin
          sw_ack_d   = 1'b1;
          sw_err_d   = !fin_ok;
          sw_rdata_d = (fin_ok && !wr_q) ? sie_regrd : 8'h00;
        end
      end
    end

    ready_d = ready_q | (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      owner_q     <= 1'b0;
      sie_en_q    <= 1'b0;
      sie_cmd_q   <= 8'h00;
      sie_regwd_q <= 8'h00;
      sw_ack_q    <= 1'b0;
      sw_err_q    <= 1'b0;
      sw_rdata_q  <= 8'h00;
      lk_ack_q    <= 1'b0;
      lk_err_q    <= 1'b0;
      lk_rdata_q  <= 8'h00;
      ready_q     <= 1'b0;
`ifdef ULPI_PHY_CTRL_INIT_EN
      vid_lo_q    <= 8'h00;
      init_err_q  <= 1'b0;
      init_acc_q  <= 1'b0;
      ret_q       <= ST_DONE;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      owner_q     <= owner_d;
      sie_en_q    <= sie_en_d;
      sie_cmd_q   <= sie_cmd_d;
      sie_regwd_q <= sie_regwd_d;
      sw_ack_q    <= sw_ack_d;
      sw_err_q    <= sw_err_d;
      sw_rdata_q  <= sw_rdata_d;
      lk_ack_q    <= lk_ack_d;
      lk_err_q    <= lk_err_d;
      lk_rdata_q  <= lk_rdata_d;
      ready_q     <= ready_d;
`ifdef ULPI_PHY_CTRL_INIT_EN
      vid_lo_q    <= vid_lo_d;
      init_err_q  <= init_err_d;
      init_acc_q  <= init_acc_d;
      ret_q       <= ret_d;
`endif
    end
  end

  assign sie_en    = sie_en_q;
  assign sie_cmd   = sie_cmd_q;
  assign sie_regwd = sie_regwd_q;
  assign sw_ack    = sw_ack_q;
  assign sw_err    = sw_err_q;
  assign sw_rdata  = sw_rdata_q;
  assign lk_ack    = lk_ack_q;
  assign lk_err    = lk_err_q;
  assign lk_rdata  = lk_rdata_q;
  assign ready     = ready_q;
`ifdef ULPI_PHY_CTRL_INIT_EN
  assign vid_lo    = vid_lo_q;
  assign init_err  = init_err_q;
`else
  assign vid_lo    = 8'h00;
  assign init_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ulpi_phy_ctrl.sv
// Self-checking bench for ulpi_phy_ctrl with a behavioural SIE responder and an
// expected-ack scoreboard; init checks follow ULPI_PHY_CTRL_INIT_EN.
module tb_ulpi_phy_ctrl;

  localparam int TO = 1023;

  logic       clk, rst_n;
  logic       sw_req, sw_wr, sw_ack, sw_err;
  logic [5:0] sw_addr;
  logic [7:0] sw_wdata, sw_rdata;
  logic       lk_req, lk_wr, lk_ack, lk_err;
  logic [5:0] lk_addr;
  logic [7:0] lk_wdata, lk_rdata;
  logic       sie_en, sie_busy, ready, init_err;
  logic [7:0] sie_cmd, sie_regwd, sie_regrd, vid_lo;

  ulpi_phy_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .sw_req(sw_req), .sw_wr(sw_wr), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_ack(sw_ack), .sw_rdata(sw_rdata), .sw_err(sw_err),
    .lk_req(lk_req), .lk_wr(lk_wr), .lk_addr(lk_addr), .lk_wdata(lk_wdata),
    .lk_ack(lk_ack), .lk_rdata(lk_rdata), .lk_err(lk_err),
    .sie_en(sie_en), .sie_cmd(sie_cmd), .sie_regwd(sie_regwd),
    .sie_regrd(sie_regrd), .sie_busy(sie_busy),
    .ready(ready), .vid_lo(vid_lo), .init_err(init_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       port;   // 0 = sw, 1 = lk
    logic       err;
    logic       chk;    // compare rdata
    logic [7:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_cmd[$];
  logic [7:0] obs_wd[$];
  int         stable_err = 0;
  bit         sie_mute = 1'b0;
  logic [7:0] rd_next = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;

  // SIE responder: busy rises 2 cycles after en is seen, stays 3 cycles
  initial begin : sie_model
    logic [7:0] c, w;
    sie_busy  = 1'b0;
    sie_regrd = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rst_n && sie_en && !sie_mute) begin
        c = sie_cmd;
        w = sie_regwd;
        obs_cmd.push_back(c);
        obs_wd.push_back(w);
        repeat (2) begin @(posedge clk); #1; end
        sie_busy = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          if (rst_n && (sie_cmd !== c || sie_regwd !== w)) stable_err++;
        end
        sie_regrd = rd_next;
        rd_next   = rd_next + 8'h01;
        sie_busy  = 1'b0;
      end
    end
  end

  task automatic wait_ack(input int budget, output bit got, output logic port,
                          output logic err, output logic [7:0] data);
    got = 1'b0; port = 1'b0; err = 1'b0; data = 8'h00;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      if (sw_ack) begin
        got = 1'b1; port = 1'b0; err = sw_err; data = sw_rdata;
      end else if (lk_ack) begin
        got = 1'b1; port = 1'b1; err = lk_err; data = lk_rdata;
      end
    end
    if (got) $display("[TB] ack port=%s err=%0d rdata=%02h cycle=%0d",
                      port ? "lk" : "sw", err, data, cyc);
  endtask

  task automatic check_outputs_reset(input string tag);
    n_tests++;
    if ({sie_en, sie_cmd, sie_regwd} !== 17'h0) begin
      n_fail++;
      $display("FAIL %s_sie: got en=%b cmd=%02h wd=%02h required 0/00/00", tag, sie_en, sie_cmd, sie_regwd);
    end
    n_tests++;
    if ({sw_ack, sw_err, sw_rdata} !== 10'h0) begin
      n_fail++;
      $display("FAIL %s_sw: got ack=%b err=%b rdata=%02h required 0/0/00", tag, sw_ack, sw_err, sw_rdata);
    end
    n_tests++;
    if ({lk_ack, lk_err, lk_rdata} !== 10'h0) begin
      n_fail++;
      $display("FAIL %s_lk: got ack=%b err=%b rdata=%02h required 0/0/00", tag, lk_ack, lk_err, lk_rdata);
    end
    n_tests++;
    if ({ready, vid_lo, init_err} !== 10'h0) begin
      n_fail++;
      $display("FAIL %s_status: got ready=%b vid=%02h ierr=%b required 0/00/0", tag, ready, vid_lo, init_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_req = 1'b0; sw_wr = 1'b0; sw_addr = 6'h00; sw_wdata = 8'h00;
    lk_req = 1'b0; lk_wr = 1'b0; lk_addr = 6'h00; lk_wdata = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    obs_cmd.delete(); obs_wd.delete();
    rd_next = 8'h24;
    rst_n = 1'b1;
  endtask

`ifdef ULPI_PHY_CTRL_INIT_EN
  task automatic test_init();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL init_ready: got ready=%b required 1 within 200 cycles", ready); end
    n_tests++;
    if (vid_lo !== 8'h24) begin n_fail++; $display("FAIL init_vid: got %02h required 24", vid_lo); end
    n_tests++;
    if (init_err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %b required 0", init_err); end
    n_tests++;
    if (obs_cmd.size() != 3) begin
      n_fail++; $display("FAIL init_count: got %0d accesses required 3", obs_cmd.size());
    end else begin
      n_tests++;
      if ({obs_cmd[0], obs_cmd[1], obs_wd[1], obs_cmd[2], obs_wd[2]} !== 40'hC0_8A_00_84_40) begin
        n_fail++;
        $display("FAIL init_seq: got %02h %02h/%02h %02h/%02h required C0 8A/00 84/40",
                 obs_cmd[0], obs_cmd[1], obs_wd[1], obs_cmd[2], obs_wd[2]);
      end
    end
  endtask
`else
  task automatic test_no_init();
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL noinit_ready0: got %b required 0", ready); end
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL noinit_ready1: got %b required 1", ready); end
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (obs_cmd.size() != 0 || sie_en !== 1'b0) begin
      n_fail++; $display("FAIL noinit_idle: got %0d accesses en=%b required 0/0", obs_cmd.size(), sie_en);
    end
    n_tests++;
    if ({vid_lo, init_err} !== 9'h0) begin
      n_fail++; $display("FAIL noinit_status: got vid=%02h ierr=%b required 00/0", vid_lo, init_err);
    end
  endtask
`endif

  task automatic test_rr_reads();
    bit got; logic port, err; logic [7:0] data; exp_t e;
    int sw_left = 2, lk_left = 2;
    exp_q.delete(); obs_cmd.delete(); obs_wd.delete();
    rd_next = 8'h30;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.port = i[0]; x.err = 1'b0; x.chk = 1'b1; x.rdata = 8'h30 + 8'(i);
      exp_q.push_back(x);
    end
    sw_wr = 1'b0; sw_addr = 6'h01; lk_wr = 1'b0; lk_addr = 6'h01;
    sw_req = 1'b1; lk_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(200, got, port, err, data);
      n_tests++;
      if (!got) begin n_fail++; $display("FAIL rr_wait: no ack for access %0d required ack", i); break; end
      e = exp_q.pop_front();
      n_tests++;
      if (port !== e.port) begin n_fail++; $display("FAIL rr_order%0d: got port %0d required %0d", i, port, e.port); end
      n_tests++;
      if (err !== e.err) begin n_fail++; $display("FAIL rr_err%0d: got %b required %b", i, err, e.err); end
      n_tests++;
      if (e.chk && data !== e.rdata) begin n_fail++; $display("FAIL rr_data%0d: got %02h required %02h", i, data, e.rdata); end
      if (port) begin lk_left--; if (lk_left == 0) lk_req = 1'b0; end
      else begin sw_left--; if (sw_left == 0) sw_req = 1'b0; end
    end
    sw_req = 1'b0; lk_req = 1'b0;
    foreach (obs_cmd[k]) begin
      n_tests++;
      if (obs_cmd[k] !== 8'hC1) begin n_fail++; $display("FAIL rr_cmd%0d: got %02h required C1", k, obs_cmd[k]); end
    end
  endtask

  task automatic test_sw_write();
    bit got; logic port, err; logic [7:0] data; exp_t e, x;
    int st0, t0, extra;
    exp_q.delete(); obs_cmd.delete(); obs_wd.delete();
    x.port = 1'b0; x.err = 1'b0; x.chk = 1'b0; x.rdata = 8'h00;
    exp_q.push_back(x);
    st0 = stable_err;
    repeat (2) @(posedge clk);
    #1;
    sw_wr = 1'b1; sw_addr = 6'h16; sw_wdata = 8'h5A; sw_req = 1'b1;
    t0 = cyc;
    wait_ack(200, got, port, err, data);
    sw_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL wr_wait: no ack required ack");
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (port !== e.port || err !== e.err) begin
        n_fail++; $display("FAIL wr_ack: got port=%0d err=%b required %0d/%b", port, err, e.port, e.err);
      end
      n_tests++;
      if (cyc - t0 < 7) begin n_fail++; $display("FAIL wr_latency: got %0d cycles required >= 7", cyc - t0); end
    end
    n_tests++;
    if (obs_cmd.size() != 1) begin
      n_fail++; $display("FAIL wr_count: got %0d accesses required 1", obs_cmd.size());
    end else begin
      n_tests++;
      if ({obs_cmd[0], obs_wd[0]} !== 16'h965A) begin
        n_fail++; $display("FAIL wr_cmd: got %02h/%02h required 96/5A", obs_cmd[0], obs_wd[0]);
      end
    end
    n_tests++;
    if (stable_err != st0) begin n_fail++; $display("FAIL wr_stable: got %0d changes required 0", stable_err - st0); end
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (sw_ack || lk_ack) extra++; end
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL wr_single_ack: got %0d extra acks required 0", extra); end
  endtask

  task automatic test_timeout();
    bit got; logic port, err; logic [7:0] data; exp_t e, x;
    int t_en = -1;
    exp_q.delete();
    x.port = 1'b0; x.err = 1'b1; x.chk = 1'b1; x.rdata = 8'h00;
    exp_q.push_back(x);
    sie_mute = 1'b1;
    sw_wr = 1'b0; sw_addr = 6'h02; sw_req = 1'b1;
    for (int i = 0; i < 20 && t_en < 0; i++) begin
      @(posedge clk); #1;
      if (sie_en) t_en = cyc;
    end
    n_tests++;
    if (t_en < 0) begin n_fail++; $display("FAIL to_en: got sie_en=0 required 1 within 20 cycles"); end
    wait_ack(TO + 20, got, port, err, data);
    sw_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL to_wait: no ack required ack");
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (cyc - t_en != TO) begin n_fail++; $display("FAIL to_cycles: got %0d required %0d", cyc - t_en, TO); end
      n_tests++;
      if (port !== e.port || err !== e.err || data !== e.rdata) begin
        n_fail++; $display("FAIL to_ack: got port=%0d err=%b rdata=%02h required %0d/%b/%02h",
                           port, err, data, e.port, e.err, e.rdata);
      end
      n_tests++;
      if (sie_en !== 1'b0) begin n_fail++; $display("FAIL to_en_drop: got %b required 0", sie_en); end
    end
    @(posedge clk); #1;
    sie_mute = 1'b0;
    rd_next = 8'h6C;
    x.port = 1'b0; x.err = 1'b0; x.chk = 1'b1; x.rdata = 8'h6C;
    exp_q.push_back(x);
    sw_wr = 1'b0; sw_addr = 6'h05; sw_req = 1'b1;
    wait_ack(200, got, port, err, data);
    sw_req = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL to_recover_wait: no ack required ack");
    end else begin
      e = exp_q.pop_front();
      n_tests++;
      if (port !== e.port || err !== e.err || data !== e.rdata) begin
        n_fail++; $display("FAIL to_recover: got port=%0d err=%b rdata=%02h required %0d/%b/%02h",
                           port, err, data, e.port, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sw_wr = 1'b0; sw_addr = 6'h03; sw_req = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (sie_busy) seen = 1'b1;
    end
    @(posedge clk); #1;
    n_tests++;
    if (!seen || sie_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wait: got busy_seen=%b en=%b required 1/0", seen, sie_en);
    end
    @(negedge clk);
    rst_n = 1'b0;
    sw_req = 1'b0;
    #1;
    check_outputs_reset("rstmid");
    repeat (8) @(posedge clk);
    rd_next = 8'h77;
    obs_cmd.delete(); obs_wd.delete();
    #1;
    rst_n = 1'b1;
`ifdef ULPI_PHY_CTRL_INIT_EN
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    n_tests++;
    if (!seen || vid_lo !== 8'h77) begin
      n_fail++; $display("FAIL rstmid_reinit: got ready=%b vid=%02h required 1/77", ready, vid_lo);
    end
    n_tests++;
    if (obs_cmd.size() != 3) begin
      n_fail++; $display("FAIL rstmid_count: got %0d accesses required 3", obs_cmd.size());
    end
`else
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", ready); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (obs_cmd.size() != 0) begin
      n_fail++; $display("FAIL rstmid_idle: got %0d accesses required 0", obs_cmd.size());
    end
`endif
  endtask

  initial begin
    test_reset();
`ifdef ULPI_PHY_CTRL_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_rr_reads();
    test_sw_write();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
